// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: aging request queue issuing the oldest eligible entry (MODE 0) or a row hit with starvation guard (MODE 1)
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            request handshake; in_op, in_addr, in_time request fields
//   out_valid/out_ready          issue handshake; out_op, out_addr, out_time fields of the issued entry
//   count, full, empty           occupancy status
//   cur_time                     scheduler time, skips forward to in_time while idle
module mem_req_scheduler #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 33,
    parameter int TIME_W  = 64,
    parameter int AGE_W   = 8,
    parameter int MIN_AGE = 100,
    parameter int AGE_MAX = 200,
    parameter int ROW_LSB = 18,
    parameter int ROW_W   = 15,
    parameter int MODE    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [TIME_W-1:0]            in_time,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_op,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [TIME_W-1:0]            out_time,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [TIME_W-1:0]            cur_time
);
    localparam int CW = $clog2(DEPTH+1);

    logic [1:0]        op_q   [DEPTH];
    logic [1:0]        op_d   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [TIME_W-1:0] tim_q  [DEPTH];
    logic [TIME_W-1:0] tim_d  [DEPTH];
    logic [AGE_W-1:0]  age_q  [DEPTH];
    logic [AGE_W-1:0]  age_d  [DEPTH];
    logic [CW-1:0]     count_q, count_d, sel_q, sel_d, pick, oidx, tail, el_idx, hit_idx;
    logic [TIME_W-1:0] cur_time_q, cur_time_d;
    logic [ROW_W-1:0]  last_row_q, last_row_d;
    logic              last_row_vld_q, last_row_vld_d, hold_q, hold_d;
    logic [DEPTH-1:0]  elig, hit;
    logic              accept, pop;

    function automatic logic [AGE_W-1:0] inc_age(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = (CW'(i) < count_q) && (age_q[i] >= AGE_W'(MIN_AGE));
            hit[i]  = elig[i] && last_row_vld_q && (addr_q[i][ROW_LSB +: ROW_W] == last_row_q);
        end
    end

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        el_idx  = '0;
        hit_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (elig[i]) el_idx = CW'(i);
            if (hit[i]) hit_idx = CW'(i);
        end
        pick = (MODE == 1 && count_q != '0 && age_q[0] >= AGE_W'(AGE_MAX)) ? '0 :
               (MODE == 1 && |hit) ? hit_idx : el_idx;
    end

    // A held selection stays valid: only the held entry can be popped, inserts go to the tail.
    assign oidx      = hold_q ? sel_q : pick;
    assign out_valid = hold_q || |elig;
    assign pop       = out_valid && out_ready;
    assign in_ready  = (count_q < CW'(DEPTH)) && (cur_time_q >= in_time);
    assign accept    = in_valid && in_ready;
    assign count     = count_q;
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign cur_time  = cur_time_q;

    always_comb begin
        out_op   = '0;
        out_addr = '0;
        out_time = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (out_valid && CW'(i) == oidx) begin
                out_op   = op_q[i];
                out_addr = addr_q[i];
                out_time = tim_q[i];
            end
        end
    end

    always_comb begin
        tail = count_q - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            op_d[i]   = op_q[i];
            addr_d[i] = addr_q[i];
            tim_d[i]  = tim_q[i];
            age_d[i]  = (CW'(i) < count_q) ? inc_age(age_q[i]) : '0;
        end
        for (int i = 0; i < DEPTH-1; i++) begin
            if (pop && CW'(i) >= oidx) begin
                op_d[i]   = op_q[i+1];
                addr_d[i] = addr_q[i+1];
                tim_d[i]  = tim_q[i+1];
                age_d[i]  = (CW'(i+1) < count_q) ? inc_age(age_q[i+1]) : '0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && CW'(i) == tail) begin
                op_d[i]   = in_op;
                addr_d[i] = in_addr;
                tim_d[i]  = in_time;
                age_d[i]  = '0;
            end
        end
        count_d        = count_q + CW'(accept) - CW'(pop);
        cur_time_d     = (empty && in_valid && in_time > cur_time_q) ? in_time : cur_time_q + 1'b1;
        last_row_d     = pop ? out_addr[ROW_LSB +: ROW_W] : last_row_q;
        last_row_vld_d = last_row_vld_q || pop;
        hold_d         = out_valid && !pop;
        sel_d          = oidx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                addr_q[i] <= '0;
                tim_q[i]  <= '0;
                age_q[i]  <= '0;
            end
            count_q        <= '0;
            cur_time_q     <= '0;
            last_row_q     <= '0;
            last_row_vld_q <= 1'b0;
            hold_q         <= 1'b0;
            sel_q          <= '0;
        end else begin
            op_q           <= op_d;
            addr_q         <= addr_d;
            tim_q          <= tim_d;
            age_q          <= age_d;
            count_q        <= count_d;
            cur_time_q     <= cur_time_d;
            last_row_q     <= last_row_d;
            last_row_vld_q <= last_row_vld_d;
            hold_q         <= hold_d;
            sel_q          <= sel_d;
        end
    end
endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler: scoreboard bench for mem_req_scheduler in both scheduling modes
module tb_mem_req_scheduler;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 33;
    localparam int TIME_W = 64;
    localparam int CW     = 5;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [TIME_W-1:0] tim;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready;
    logic [1:0] in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [TIME_W-1:0] in_time;
    logic in_ready0, out_valid0, full0, empty0, in_ready1, out_valid1, full1, empty1;
    logic [1:0] out_op0, out_op1;
    logic [ADDR_W-1:0] out_addr0, out_addr1;
    logic [TIME_W-1:0] out_time0, out_time1, cur_time0, cur_time1;
    logic [CW-1:0] count0, count1;

    req_t sbq[$];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    mem_req_scheduler #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_op(in_op),
        .in_addr(in_addr), .in_time(in_time), .out_valid(out_valid0), .out_ready(out_ready),
        .out_op(out_op0), .out_addr(out_addr0), .out_time(out_time0), .count(count0),
        .full(full0), .empty(empty0), .cur_time(cur_time0)
    );

    mem_req_scheduler #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_op(in_op),
        .in_addr(in_addr), .in_time(in_time), .out_valid(out_valid1), .out_ready(out_ready),
        .out_op(out_op1), .out_addr(out_addr1), .out_time(out_time1), .count(count1),
        .full(full1), .empty(empty1), .cur_time(cur_time1)
    );

    function automatic logic [ADDR_W-1:0] mk(input int row, input int low);
        return {row[14:0], low[17:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input req_t r);
        in_valid = 1'b1;
        in_op    = r.op;
        in_addr  = r.addr;
        in_time  = r.tim;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_time = '0;
        out_ready = 1'b0;
        sbq.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = '0;
        in_addr = '0;
        in_time = '0;
        out_ready = 1'b0;
        step();
        step();
        total++; if (count0 !== 0) $display("FAIL reset_count got %0d exp 0", count0); else passed++;
        total++; if (empty0 !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty0); else passed++;
        total++; if (full0 !== 1'b0) $display("FAIL reset_full got %b exp 0", full0); else passed++;
        total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid0); else passed++;
        total++; if (cur_time0 !== 0) $display("FAIL reset_cur_time got %0d exp 0", cur_time0); else passed++;
        total++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready0); else passed++;
        total++; if (out_addr0 !== 0) $display("FAIL reset_out_addr got %h exp 0", out_addr0); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_time_skip();
        req_t r, e;
        int n;
        do_reset();
        n = 0;
        while (cur_time0 != 10 && n < 50) begin step(); n++; end
        total++; if (cur_time0 !== 10) $display("FAIL ts_start_time got %0d exp 10", cur_time0); else passed++;
        r = '{op: 2'd2, addr: mk(3, 'h111), tim: 64'd500};
        drive(r);
        #1;
        total++; if (in_ready0 !== 1'b0) $display("FAIL ts_ready_early got %b exp 0", in_ready0); else passed++;
        step();
        total++; if (cur_time0 !== 500) $display("FAIL ts_skip got %0d exp 500", cur_time0); else passed++;
        total++; if (in_ready0 !== 1'b1) $display("FAIL ts_ready got %b exp 1", in_ready0); else passed++;
        sbq.push_back(r);
        step();
        in_valid = 1'b0;
        total++; if (count0 !== 1) $display("FAIL ts_count got %0d exp 1", count0); else passed++;
        total++; if (cur_time0 !== 501) $display("FAIL ts_time_inc got %0d exp 501", cur_time0); else passed++;
        n = 0;
        while (!out_valid0 && n < 200) begin step(); n++; end
        total++; if (n !== 100) $display("FAIL ts_latency got %0d exp 100", n); else passed++;
        out_ready = 1'b1;
        #1;
        e = sbq.pop_front();
        total++; if ({out_op0, out_addr0, out_time0} !== {e.op, e.addr, e.tim})
            $display("FAIL ts_issue got %h/%h/%0d exp %h/%h/%0d", out_op0, out_addr0, out_time0, e.op, e.addr, e.tim);
        else passed++;
        step();
        out_ready = 1'b0;
        total++; if (empty0 !== 1'b1) $display("FAIL ts_empty got %b exp 1", empty0); else passed++;
    endtask

    task automatic test_full();
        req_t r, e;
        int n;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            r = '{op: 2'(k), addr: mk(k, k * 7 + 1), tim: 64'(k)};
            drive(r);
            in_time = '0;
            r.tim = '0;
            #1;
            total++; if (in_ready0 !== 1'b1) $display("FAIL full_fill_ready%0d got %b exp 1", k, in_ready0); else passed++;
            sbq.push_back(r);
            step();
        end
        r = '{op: 2'd3, addr: mk(100, 'h3ab), tim: 64'd0};
        drive(r);
        #1;
        total++; if (full0 !== 1'b1) $display("FAIL full_flag got %b exp 1", full0); else passed++;
        total++; if (count0 !== DEPTH) $display("FAIL full_count got %0d exp %0d", count0, DEPTH); else passed++;
        total++; if (in_ready0 !== 1'b0) $display("FAIL full_ready got %b exp 0", in_ready0); else passed++;
        n = 0;
        while (!out_valid0 && n < 200) begin step(); n++; end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready0 !== 1'b0) $display("FAIL full_pop_ready got %b exp 0", in_ready0); else passed++;
        e = sbq.pop_front();
        total++; if (out_addr0 !== e.addr) $display("FAIL full_first_pop got %h exp %h", out_addr0, e.addr); else passed++;
        step();
        out_ready = 1'b0;
        #1;
        total++; if (count0 !== DEPTH-1) $display("FAIL full_after_pop got %0d exp %0d", count0, DEPTH-1); else passed++;
        total++; if (in_ready0 !== 1'b1) $display("FAIL full_ready_after got %b exp 1", in_ready0); else passed++;
        sbq.push_back(r);
        step();
        in_valid = 1'b0;
        total++; if (count0 !== DEPTH) $display("FAIL full_refill got %0d exp %0d", count0, DEPTH); else passed++;
        out_ready = 1'b1;
        n = 0;
        while (sbq.size() > 0 && n < 400) begin
            if (out_valid0) begin
                e = sbq.pop_front();
                total++; if ({out_op0, out_addr0, out_time0} !== {e.op, e.addr, e.tim})
                    $display("FAIL full_drain got %h/%h exp %h/%h", out_op0, out_addr0, e.op, e.addr);
                else passed++;
            end
            step();
            n++;
        end
        out_ready = 1'b0;
        total++; if (sbq.size() !== 0) $display("FAIL full_drain_timeout got %0d left exp 0", sbq.size()); else passed++;
        total++; if (empty0 !== 1'b1) $display("FAIL full_drained got %b exp 1", empty0); else passed++;
    endtask

    task automatic test_fifo_order();
        req_t r, e;
        int n;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r = '{op: 2'(k + 1), addr: mk(20 + k, 'h500 + k), tim: 64'd0};
            drive(r);
            #1;
            total++; if (in_ready0 !== 1'b1) $display("FAIL fifo_accept%0d got %b exp 1", k, in_ready0); else passed++;
            sbq.push_back(r);
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid0 && n < 200) begin step(); n++; end
        for (int k = 0; k < 3; k++) begin
            e = sbq.pop_front();
            total++; if ({out_valid0, out_op0, out_addr0} !== {1'b1, e.op, e.addr})
                $display("FAIL fifo_issue%0d got %b/%h/%h exp 1/%h/%h", k, out_valid0, out_op0, out_addr0, e.op, e.addr);
            else passed++;
            step();
        end
        out_ready = 1'b0;
        total++; if (empty0 !== 1'b1) $display("FAIL fifo_empty got %b exp 1", empty0); else passed++;
    endtask

    task automatic test_row_hit(input int wait_n, input logic expect_old);
        req_t p, x, y;
        do_reset();
        p = '{op: 2'd1, addr: mk(5, 'h10), tim: 64'd0};
        x = '{op: 2'd2, addr: mk(7, 'h20), tim: 64'd0};
        y = '{op: 2'd3, addr: mk(5, 'h30), tim: 64'd0};
        drive(p); #1;
        total++; if (in_ready1 !== 1'b1) $display("FAIL row_acc_p got %b exp 1", in_ready1); else passed++;
        step();
        drive(x); step();
        drive(y); step();
        in_valid = 1'b0;
        repeat (wait_n) step();
        total++; if ({out_valid1, out_addr1} !== {1'b1, p.addr})
            $display("FAIL row_held_p got %b/%h exp 1/%h", out_valid1, out_addr1, p.addr);
        else passed++;
        out_ready = 1'b1;
        step();
        total++; if ({out_valid1, out_addr1} !== {1'b1, expect_old ? x.addr : y.addr})
            $display("FAIL row_first_%0d got %b/%h exp 1/%h", wait_n, out_valid1, out_addr1, expect_old ? x.addr : y.addr);
        else passed++;
        step();
        total++; if ({out_valid1, out_addr1} !== {1'b1, expect_old ? y.addr : x.addr})
            $display("FAIL row_second_%0d got %b/%h exp 1/%h", wait_n, out_valid1, out_addr1, expect_old ? y.addr : x.addr);
        else passed++;
        step();
        out_ready = 1'b0;
        total++; if (empty1 !== 1'b1) $display("FAIL row_empty got %b exp 1", empty1); else passed++;
    endtask

    task automatic test_hold();
        req_t x, y, z;
        int n;
        x = '{op: 2'd1, addr: mk(7, 'h40), tim: 64'd0};
        y = '{op: 2'd2, addr: mk(5, 'h50), tim: 64'd0};
        z = '{op: 2'd3, addr: mk(9, 'h60), tim: 64'd0};
        out_ready = 1'b0;
        drive(x); step();
        in_valid = 1'b0;
        repeat (10) step();
        drive(y); step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid1 && n < 200) begin step(); n++; end
        for (int k = 0; k < 25; k++) begin
            total++; if ({out_valid1, out_addr1} !== {1'b1, x.addr})
                $display("FAIL hold_cycle%0d got %b/%h exp 1/%h", k, out_valid1, out_addr1, x.addr);
            else passed++;
            step();
        end
        out_ready = 1'b1;
        drive(z);
        #1;
        total++; if (in_ready1 !== 1'b1) $display("FAIL hold_swap_ready got %b exp 1", in_ready1); else passed++;
        total++; if (out_addr1 !== x.addr) $display("FAIL hold_release got %h exp %h", out_addr1, x.addr); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (count1 !== 2) $display("FAIL hold_swap_count got %0d exp 2", count1); else passed++;
        total++; if ({out_valid1, out_addr1} !== {1'b1, y.addr})
            $display("FAIL hold_next got %b/%h exp 1/%h", out_valid1, out_addr1, y.addr);
        else passed++;
        step();
        out_ready = 1'b0;
        n = 0;
        while (!out_valid1 && n < 200) begin step(); n++; end
        total++; if ({out_valid1, out_op1, out_addr1} !== {1'b1, z.op, z.addr})
            $display("FAIL hold_tail got %b/%h/%h exp 1/%h/%h", out_valid1, out_op1, out_addr1, z.op, z.addr);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (empty1 !== 1'b1) $display("FAIL hold_empty got %b exp 1", empty1); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive('{op: 2'(k), addr: mk(30 + k, k), tim: 64'd0});
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid0 && n < 200) begin step(); n++; end
        total++; if ({out_valid0, count0} !== {1'b1, 5'd5})
            $display("FAIL mid_pre got %b/%0d exp 1/5", out_valid0, count0);
        else passed++;
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        total++; if (count0 !== 0) $display("FAIL mid_count got %0d exp 0", count0); else passed++;
        total++; if (out_valid0 !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", out_valid0); else passed++;
        total++; if (cur_time0 !== 0) $display("FAIL mid_cur_time got %0d exp 0", cur_time0); else passed++;
        total++; if (out_addr0 !== 0) $display("FAIL mid_out_addr got %h exp 0", out_addr0); else passed++;
        out_ready = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_time_skip();
        test_full();
        test_fifo_order();
        test_row_hit(148, 1'b0);
        test_row_hit(198, 1'b1);
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout passed %0d of %0d", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of request entries (power of two not required, >=2).
REQ-002 SHALL have parameter ADDR_W, default 33: request address width.
REQ-003 SHALL have parameter TIME_W, default 64: CPU-time / simulation-time width.
REQ-004 SHALL have parameter AGE_W, default 8: per-entry age counter width.
REQ-005 SHALL have parameter MIN_AGE, default 100: age at which an entry becomes eligible to issue.
REQ-006 SHALL have parameter AGE_MAX, default 200 (MIN_AGE <= AGE_MAX < 2^AGE_W): starvation age forcing oldest issue.
REQ-007 SHALL have parameters ROW_LSB, default 18, and ROW_W, default 15: row field position in address.
REQ-008 SHALL have parameter MODE, default 0: 0 = oldest-eligible FIFO, 1 = row-hit-first with starvation guard.
REQ-009 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have ports: in_valid in 1 request offered; in_ready out 1 request accepted this cycle when both high.
REQ-011 SHALL have ports: in_op in 2 opcode; in_addr in ADDR_W address; in_time in TIME_W request CPU time.
REQ-012 SHALL have ports: out_valid out 1 issue offered; out_ready in 1 downstream takes issue when both high.
REQ-013 SHALL have ports: out_op out 2; out_addr out ADDR_W; out_time out TIME_W; fields of issued entry.
REQ-014 SHALL have ports: count out $clog2(DEPTH+1) occupancy; full out 1; empty out 1; cur_time out TIME_W scheduler time.

Function
REQ-015 SHALL store entries in insertion order, slot 0 oldest; pop SHALL remove the entry and compact younger entries down one slot in the same cycle.
REQ-016 SHALL increment cur_time by 1 every cycle, except when empty=1, in_valid=1 and in_time>cur_time, where cur_time SHALL load in_time (time skip).
REQ-017 SHALL drive in_ready = (count<DEPTH) && (cur_time >= in_time), combinationally; in_ready SHALL NOT depend on out_ready.
REQ-018 SHALL write an accepted request at slot count (after any same-cycle compaction) with age 0.
REQ-019 SHALL increment each occupied entry's age by 1 per cycle, saturating at 2^AGE_W-1.
REQ-020 SHALL mark an entry eligible when age >= MIN_AGE; out_valid SHALL be 1 iff an issue selection is held or any entry is eligible.
REQ-021 MODE 0: SHALL select the lowest-slot eligible entry.
REQ-022 MODE 1: if slot 0 age >= AGE_MAX SHALL select slot 0; else lowest-slot eligible entry whose row field equals last_row with last_row_vld=1; else lowest-slot eligible entry.
REQ-023 SHALL latch the selected slot index when out_valid rises; out_* SHALL stay constant until out_valid&&out_ready, regardless of new eligibility or inserts.
REQ-024 On out_valid&&out_ready SHALL pop the held entry, update last_row from its address, set last_row_vld=1, release the hold; a new selection MAY be presented next cycle.
REQ-025 Simultaneous accept and pop SHALL leave count unchanged; the new entry SHALL land at the tail after compaction; accept when full with same-cycle pop is NOT permitted (in_ready=0).
REQ-026 SHALL drive full=(count==DEPTH), empty=(count==0); out_* SHALL be 0 when out_valid=0.
REQ-027 At most one accept and one pop SHALL occur per cycle.

Reset
REQ-028 While rst=1 SHALL clear all entries, count=0, cur_time=0, last_row=0, last_row_vld=0, hold released, out_valid=0, in_ready as per REQ-017 with count=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately, including a held issue; no pop SHALL complete in that cycle.

Verification
REQ-030 Empty, offer in_time=500 at cur_time=10 -> cur_time=500 next cycle, accept following cycle, out_valid exactly MIN_AGE cycles after accept.
REQ-031 Fill DEPTH entries, out_ready=0 -> full=1, in_ready=0, count=DEPTH; one pop with new offer same cycle -> count stays DEPTH-1+... no accept that cycle, accept next cycle.
REQ-032 MODE 0, three entries A,B,C accepted on consecutive cycles, out_ready=1 -> issued A,B,C in order, one per cycle from A's eligibility.
REQ-033 MODE 1, last_row=5, eligible slots: 0 row 7 (age 150), 1 row 5 -> slot 1 issues first; repeat with slot 0 age 200 -> slot 0 issues first.
REQ-034 out_valid=1, out_ready=0 for 20 cycles while a row-hit entry becomes eligible -> out_* unchanged until handshake.
REQ-035 Assert rst with 5 entries and a held issue -> next cycle count=0, out_valid=0, cur_time=0.
